// File: rtl/arcade_input_conditioner.sv
// ---------------------------------------------------------------------------
// arcade_input_conditioner
//
// Conditions the HPS joystick word for the Berzerk core. Each of the nine
// used buttons is synchronised, then debounced against a millisecond-class
// timebase. Opposing directions cancel to neutral. Coin presses are queued
// (up to three) and replayed as fixed-width, rate-limited coin pulses that
// are held off while the CPU is paused.
//
// Ports:
//   clk_sys     in   1   system clock (single domain)
//   reset_n     in   1   synchronous active-low reset
//   joy_in      in  16   [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2
//                        [7]coin [8]pause, [15:9] unused
//   pause       in   1   CPU paused; blocks the start of a new coin pulse
//   right1..fire1 out 1  conditioned controls
//   start1/2    out  1   debounced start buttons
//   coin1       out  1   shaped coin pulse
//   pause_req   out  1   one-cycle pulse on debounced press of joy_in[8]
//   coin_queue  out  2   pending coin count, saturating at 3
// ---------------------------------------------------------------------------
module arcade_input_conditioner #(
    parameter int TICK_DIV   = 40000,
    parameter int DB_TICKS   = 5,
    parameter int COIN_TICKS = 50,
    parameter int GAP_TICKS  = 50
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] joy_in,
    input  logic        pause,
    output logic        right1,
    output logic        left1,
    output logic        down1,
    output logic        up1,
    output logic        fire1,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        pause_req,
    output logic [1:0]  coin_queue
);

    localparam int          CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] PRESC_LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0]  DB_LAST    = 8'(DB_TICKS - 1);
    localparam logic [7:0]  COIN_LAST  = 8'(COIN_TICKS - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(GAP_TICKS - 1);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_PULSE   = 2'd1;
    localparam logic [1:0]  ST_GAP     = 2'd2;

    logic [CW-1:0] presc_r;
    logic          tick_s;
    logic [8:0]    sync1_r;
    logic [8:0]    sync2_r;
    logic [8:0]    db_r;
    logic [7:0]    db_cnt_r [0:8];
    logic          coin_d_r;
    logic          pause_d_r;
    logic          coin_edge_s;
    logic          deq_s;
    logic [1:0]    queue_r;
    logic [1:0]    queue_nxt_s;
    logic [1:0]    state_r;
    logic [7:0]    timer_r;
    logic          coin_r;
    logic          right_r;
    logic          left_r;
    logic          down_r;
    logic          up_r;
    logic          fire_r;
    logic          start1_r;
    logic          start2_r;
    logic          pause_req_r;
    logic          unused_s;

    // Upper joystick bits carry nothing for this core.
    assign unused_s = ^joy_in[15:9];

    // Timebase prescaler: counts 0..TICK_DIV-1 and wraps.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            presc_r <= CW'(0);
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= CW'(0);
        end else begin
            presc_r <= presc_r + CW'(1);
        end
    end

    assign tick_s = (presc_r == PRESC_LAST);

    // Two-flop synchroniser on the nine used joystick bits.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync1_r <= 9'd0;
            sync2_r <= 9'd0;
        end else begin
            sync1_r <= joy_in[8:0];
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: a difference must persist for DB_TICKS ticks in a
    // row; any return to agreement restarts the count from zero.
    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < 9; i++) begin
            if (!reset_n) begin
                db_cnt_r[i] <= 8'd0;
                db_r[i]     <= 1'b0;
            end else if (sync2_r[i] == db_r[i]) begin
                db_cnt_r[i] <= 8'd0;
            end else if (tick_s) begin
                if (db_cnt_r[i] == DB_LAST) begin
                    db_r[i]     <= sync2_r[i];
                    db_cnt_r[i] <= 8'd0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + 8'd1;
                end
            end
        end
    end

    // Registered controls with opposing-direction suppression, plus the
    // delayed copies used for edge detection on coin and pause.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            right_r     <= 1'b0;
            left_r      <= 1'b0;
            down_r      <= 1'b0;
            up_r        <= 1'b0;
            fire_r      <= 1'b0;
            start1_r    <= 1'b0;
            start2_r    <= 1'b0;
            pause_req_r <= 1'b0;
            pause_d_r   <= 1'b0;
            coin_d_r    <= 1'b0;
        end else begin
            right_r     <= db_r[0] & ~db_r[1];
            left_r      <= db_r[1] & ~db_r[0];
            down_r      <= db_r[2] & ~db_r[3];
            up_r        <= db_r[3] & ~db_r[2];
            fire_r      <= db_r[4];
            start1_r    <= db_r[5];
            start2_r    <= db_r[6];
            pause_req_r <= db_r[8] & ~pause_d_r;
            pause_d_r   <= db_r[8];
            coin_d_r    <= db_r[7];
        end
    end

    assign coin_edge_s = db_r[7] & ~coin_d_r;
    assign deq_s       = (state_r == ST_IDLE) && (queue_r != 2'd0) && !pause;

    // Next queue depth: a coincident press and dequeue cancel out, and a
    // press arriving with three already pending is dropped.
    always_comb begin
        queue_nxt_s = queue_r;
        case ({coin_edge_s, deq_s})
            2'b10: begin
                if (queue_r == 2'd3) begin
                    queue_nxt_s = 2'd3;
                end else begin
                    queue_nxt_s = queue_r + 2'd1;
                end
            end
            2'b01:   queue_nxt_s = queue_r - 2'd1;
            default: queue_nxt_s = queue_r;
        endcase
    end

    // Pending coin counter.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            queue_r <= 2'd0;
        end else begin
            queue_r <= queue_nxt_s;
        end
    end

    // Coin pulse shaper. Pause only prevents leaving IDLE; a pulse or gap
    // already under way always runs to completion.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            timer_r <= 8'd0;
            coin_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (deq_s) begin
                        state_r <= ST_PULSE;
                        coin_r  <= 1'b1;
                        timer_r <= 8'd0;
                    end
                end
                ST_PULSE: begin
                    if (tick_s) begin
                        if (timer_r == COIN_LAST) begin
                            state_r <= ST_GAP;
                            coin_r  <= 1'b0;
                            timer_r <= 8'd0;
                        end else begin
                            timer_r <= timer_r + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick_s) begin
                        if (timer_r == GAP_LAST) begin
                            state_r <= ST_IDLE;
                            timer_r <= 8'd0;
                        end else begin
                            timer_r <= timer_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    coin_r  <= 1'b0;
                    timer_r <= 8'd0;
                end
            endcase
        end
    end

    assign right1     = right_r;
    assign left1      = left_r;
    assign down1      = down_r;
    assign up1        = up_r;
    assign fire1      = fire_r;
    assign start1     = start1_r;
    assign start2     = start2_r;
    assign coin1      = coin_r;
    assign pause_req  = pause_req_r;
    assign coin_queue = queue_r;

endmodule
